// File: rtl/fp_nth_root_seq.sv
// Iterative IEEE-754 nth root, a^(1/n), rounded toward zero, start/busy/done handshake.
// Optional macro FP_NTH_ROOT_INEXACT_EN adds an inexact flag output.
module fp_nth_root_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned N_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a_in,
  input  logic [N_W-1:0]       n_in,
  output logic                 busy,
  output logic                 done,
`ifdef FP_NTH_ROOT_INEXACT_EN
  output logic                 inexact,
`endif
  output logic [EXP_W+MAN_W:0] result
);
  localparam int unsigned W     = EXP_W + MAN_W + 1;
  localparam int unsigned M_W   = MAN_W + 1;
  localparam int unsigned N_MAX = (1 << N_W) - 1;
  localparam int unsigned P_W   = M_W * N_MAX;
  localparam int unsigned D_W   = EXP_W + 1;
  localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned CNT_W = $clog2(D_W + N_MAX + 1);
  localparam int unsigned B_W   = (MAN_W > 1) ? $clog2(MAN_W) : 1;
  localparam logic [W-1:0] QNAN = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE, CLASS, DIV, SEARCH,
`ifdef FP_NTH_ROOT_INEXACT_EN
    POW,
`endif
    FIN
  } state_t;

  state_t           state;
  logic [W-1:0]     a_q;
  logic [N_W-1:0]   n_q;
  logic             e_neg_q;
  logic [D_W-1:0]   div_q;
  logic [N_W-1:0]   rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [EXP_W-1:0] exp_q;
  logic [P_W-1:0]   xs_q;
  logic [P_W-1:0]   acc_q;
  logic [M_W-1:0]   trial_q;
  logic [M_W-1:0]   y_q;
  logic [B_W-1:0]   bit_q;

  logic             sign_a;
  logic [EXP_W-1:0] exp_a;
  logic [MAN_W-1:0] frac_a;

  assign sign_a = a_q[W-1];
  assign exp_a  = a_q[W-2:MAN_W];
  assign frac_a = a_q[MAN_W-1:0];

  // Special-operand classification
  logic             special_c;
  logic [W-1:0]     special_val_c;
  logic             e_neg_c;
  logic [EXP_W-1:0] mag_c;

  always_comb begin
    special_c     = 1'b1;
    special_val_c = QNAN;
    if (((&exp_a) && (frac_a != '0)) || (n_q == '0)) begin
      special_val_c = QNAN;
    end else if (&exp_a) begin
      special_val_c = (!sign_a || n_q[0]) ? a_q : QNAN;
    end else if (exp_a == '0) begin
      special_val_c = {sign_a, {(W-1){1'b0}}};
    end else if (n_q == N_W'(1)) begin
      special_val_c = a_q;
    end else if (sign_a && !n_q[0]) begin
      special_val_c = QNAN;
    end else begin
      special_c = 1'b0;
    end
    e_neg_c = exp_a < EXP_W'(BIAS);
    mag_c   = e_neg_c ? (EXP_W'(BIAS) - exp_a) : (exp_a - EXP_W'(BIAS));
  end

  // Restoring division step on |e|, with floor correction for negative e
  logic [N_W:0]     rem_sh_c;
  logic             div_ge_c;
  logic [N_W-1:0]   rem_nx_c;
  logic [D_W-1:0]   quo_nx_c;
  logic             rem_nz_c;
  logic [EXP_W-1:0] exp_fin_c;
  logic [N_W-1:0]   r_fin_c;
  int unsigned      sh_c;
  logic [P_W-1:0]   xs_fin_c;

  always_comb begin
    rem_sh_c = {rem_q, div_q[D_W-1]};
    div_ge_c = rem_sh_c >= {1'b0, n_q};
    rem_nx_c = div_ge_c ? N_W'(rem_sh_c - {1'b0, n_q}) : rem_sh_c[N_W-1:0];
    quo_nx_c = {div_q[D_W-2:0], div_ge_c};
    rem_nz_c = |rem_nx_c;
    if (e_neg_q) begin
      exp_fin_c = EXP_W'(D_W'(BIAS) - quo_nx_c - D_W'(rem_nz_c));
      r_fin_c   = rem_nz_c ? (n_q - rem_nx_c) : '0;
    end else begin
      exp_fin_c = EXP_W'(D_W'(BIAS) + quo_nx_c);
      r_fin_c   = rem_nx_c;
    end
    sh_c     = 32'(r_fin_c) + (32'(n_q) - 32'd1) * MAN_W;
    xs_fin_c = P_W'({1'b1, frac_a}) << sh_c;
  end

  // Significand search datapath: exact trial^n and compare against scaled X
  logic [P_W-1:0] prod_c;
  logic           le_c;
  logic [M_W-1:0] y_nx_c;
  logic [M_W-1:0] trial_nx_c;
  logic           mul_more_c;

  always_comb begin
    prod_c     = acc_q * P_W'(trial_q);
    le_c       = acc_q <= xs_q;
    y_nx_c     = le_c ? trial_q : y_q;
    trial_nx_c = y_nx_c | (M_W'(1) << (32'(bit_q) - 32'd1));
    mul_more_c = (32'(cnt_q) + 32'd1) < 32'(n_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      n_q     <= '0;
      e_neg_q <= 1'b0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      xs_q    <= '0;
      acc_q   <= '0;
      trial_q <= '0;
      y_q     <= '0;
      bit_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
`ifdef FP_NTH_ROOT_INEXACT_EN
      inexact <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a_in;
            n_q   <= n_in;
            busy  <= 1'b1;
            state <= CLASS;
          end
        end
        CLASS: begin
          if (special_c) begin
            result <= special_val_c;
`ifdef FP_NTH_ROOT_INEXACT_EN
            inexact <= 1'b0;
`endif
            done   <= 1'b1;
            state  <= FIN;
          end else begin
            e_neg_q <= e_neg_c;
            div_q   <= {1'b0, mag_c};
            rem_q   <= '0;
            cnt_q   <= '0;
            state   <= DIV;
          end
        end
        DIV: begin
          div_q <= quo_nx_c;
          rem_q <= rem_nx_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(EXP_W)) begin
            exp_q   <= exp_fin_c;
            xs_q    <= xs_fin_c;
            y_q     <= M_W'(1) << MAN_W;
            trial_q <= M_W'(3) << (MAN_W - 1);
            acc_q   <= P_W'(M_W'(3) << (MAN_W - 1));
            bit_q   <= B_W'(MAN_W - 1);
            cnt_q   <= '0;
            state   <= SEARCH;
          end
        end
        SEARCH: begin
          if (mul_more_c) begin
            acc_q <= prod_c;
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            y_q   <= y_nx_c;
            cnt_q <= '0;
            if (bit_q == '0) begin
`ifdef FP_NTH_ROOT_INEXACT_EN
              trial_q <= y_nx_c;
              acc_q   <= P_W'(y_nx_c);
              state   <= POW;
`else
              result <= {sign_a & n_q[0], exp_q, y_nx_c[MAN_W-1:0]};
              done   <= 1'b1;
              state  <= FIN;
`endif
            end else begin
              trial_q <= trial_nx_c;
              acc_q   <= P_W'(trial_nx_c);
              bit_q   <= bit_q - B_W'(1);
            end
          end
        end
`ifdef FP_NTH_ROOT_INEXACT_EN
        // Recompute y^n of the final root to flag an inexact result
        POW: begin
          acc_q <= prod_c;
          cnt_q <= cnt_q + CNT_W'(1);
          if ((32'(cnt_q) + 32'd2) == 32'(n_q)) begin
            inexact <= prod_c != xs_q;
            result  <= {sign_a & n_q[0], exp_q, y_q[MAN_W-1:0]};
            done    <= 1'b1;
            state   <= FIN;
          end
        end
`endif
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_nth_root_seq.sv
// Scoreboarded directed bench for fp_nth_root_seq (single and half precision instances).
module tb_fp_nth_root_seq;
  localparam int unsigned EW = 8, MW = 23, HEW = 5, HMW = 10;
  localparam int unsigned TIMEOUT = 400;
  localparam logic [31:0] NAN_S = 32'h7FFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_s, busy_s, done_s;
  logic [31:0] a_s, result_s;
  logic [2:0]  n_s;
  logic        start_h, busy_h, done_h;
  logic [15:0] a_h, result_h;
  logic [2:0]  n_h;
`ifdef FP_NTH_ROOT_INEXACT_EN
  logic        inexact_s, inexact_h;
`endif

  fp_nth_root_seq #(.EXP_W(EW), .MAN_W(MW), .N_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a_in(a_s), .n_in(n_s),
    .busy(busy_s), .done(done_s),
`ifdef FP_NTH_ROOT_INEXACT_EN
    .inexact(inexact_s),
`endif
    .result(result_s)
  );

  fp_nth_root_seq #(.EXP_W(HEW), .MAN_W(HMW), .N_W(3)) dut_h (
    .clk(clk), .rst_n(rst_n), .start(start_h), .a_in(a_h), .n_in(n_h),
    .busy(busy_h), .done(done_h),
`ifdef FP_NTH_ROOT_INEXACT_EN
    .inexact(inexact_h),
`endif
    .result(result_h)
  );

  typedef struct {
    logic [31:0] res;
    int unsigned lat;
    logic        inx;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int unsigned gen_lat(input bit half, input int unsigned n);
    int unsigned e = half ? HEW : EW;
    int unsigned m = half ? HMW : MW;
    gen_lat = 1 + (e + 1) + m * n + 1;
`ifdef FP_NTH_ROOT_INEXACT_EN
    gen_lat += n - 1;
`endif
  endfunction

  // Starts an op at the current negedge; returns in the cycle after done.
  task automatic run_op(input string tag, input bit half, input logic [31:0] a,
                        input logic [2:0] n, input logic [31:0] res,
                        input int unsigned lat, input logic inx, input int unsigned poke);
    exp_t        e;
    int unsigned cyc;
    bit          busy_ok;
    e.res = res; e.lat = lat; e.inx = inx;
    sb.push_back(e);
    if (half) begin a_h = a[15:0]; n_h = n; start_h = 1'b1; end
    else begin a_s = a; n_s = n; start_s = 1'b1; end
    @(negedge clk);
    start_s = 1'b0; start_h = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!(half ? done_h : done_s) && cyc < TIMEOUT) begin
      if (!(half ? busy_h : busy_s)) busy_ok = 1'b0;
      if (poke != 0 && cyc == poke) begin
        a_s = 32'h40000000; n_s = 3'd3; start_s = 1'b1;
      end
      @(negedge clk);
      start_s = 1'b0;
      cyc++;
    end
    e = sb.pop_front();
    check({tag, "_done"}, 32'(half ? done_h : done_s), 32'd1);
    check({tag, "_lat"}, cyc, e.lat);
    check({tag, "_res"}, half ? {16'h0, result_h} : result_s, e.res);
    check({tag, "_busy"}, 32'(busy_ok & (half ? busy_h : busy_s)), 32'd1);
`ifdef FP_NTH_ROOT_INEXACT_EN
    check({tag, "_inx"}, 32'(half ? inexact_h : inexact_s), 32'(e.inx));
`endif
    @(negedge clk);
    check({tag, "_pulse"}, {30'h0, half ? done_h : done_s, half ? busy_h : busy_s}, 32'd0);
    check({tag, "_hold"}, half ? {16'h0, result_h} : result_s, e.res);
  endtask

  initial begin
    rst_n = 1'b0;
    start_s = 1'b0; a_s = '0; n_s = '0;
    start_h = 1'b0; a_h = '0; n_h = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_s), 32'd0);
    check("rst_done", 32'(done_s), 32'd0);
    check("rst_result", result_s, 32'd0);
    check("rst_result_h", {16'h0, result_h}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // General cases, issued back-to-back
    run_op("sqrt16",     0, 32'h41800000, 3'd2, 32'h40800000, gen_lat(0, 2), 1'b0, 0);
    run_op("cbrt_m8",    0, 32'hC1000000, 3'd3, 32'hC0000000, gen_lat(0, 3), 1'b0, 0);
    run_op("cbrt_eigth", 0, 32'h3E000000, 3'd3, 32'h3F000000, gen_lat(0, 3), 1'b0, 0);
    run_op("sqrt2",      0, 32'h40000000, 3'd2, 32'h3FB504F3, gen_lat(0, 2), 1'b1, 0);
    run_op("root7_one",  0, 32'h3F800000, 3'd7, 32'h3F800000, gen_lat(0, 7), 1'b0, 0);

    // Special operands
    run_op("neg_even",  0, 32'hC1800000, 3'd2, NAN_S,        2, 1'b0, 0);
    run_op("n_zero",    0, 32'h41800000, 3'd0, NAN_S,        2, 1'b0, 0);
    run_op("ninf_odd",  0, 32'hFF800000, 3'd3, 32'hFF800000, 2, 1'b0, 0);
    run_op("ninf_even", 0, 32'hFF800000, 3'd2, NAN_S,        2, 1'b0, 0);
    run_op("pinf",      0, 32'h7F800000, 3'd2, 32'h7F800000, 2, 1'b0, 0);
    run_op("nzero",     0, 32'h80000000, 3'd5, 32'h80000000, 2, 1'b0, 0);
    run_op("subnorm",   0, 32'h00000001, 3'd3, 32'h00000000, 2, 1'b0, 0);
    run_op("n_one",     0, 32'h3F123456, 3'd1, 32'h3F123456, 2, 1'b0, 0);

    // Start while busy is ignored
    run_op("ign_start", 0, 32'h41800000, 3'd2, 32'h40800000, gen_lat(0, 2), 1'b0, 10);

    // Reset in the middle of an operation
    a_s = 32'h41800000; n_s = 3'd2; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_s), 32'd0);
    check("midrst_done", 32'(done_s), 32'd0);
    check("midrst_result", result_s, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (done_s) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run_op("post_rst", 0, 32'hC1000000, 3'd3, 32'hC0000000, gen_lat(0, 3), 1'b0, 0);

    // Half-precision instance
    run_op("h_sqrt16", 1, 32'h4C00, 3'd2, 32'h4400, gen_lat(1, 2), 1'b0, 0);
    run_op("h_ninf",   1, 32'hFC00, 3'd3, 32'hFC00, 2, 1'b0, 0);
    run_op("h_nan",    1, 32'h4C00, 3'd0, 32'h7FFF, 2, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_nth_root_seq.md
Name: fp_nth_root_seq

Overview:
- Iterative IEEE-754 integer nth-root unit: result = a^(1/n) for floating-point a and unsigned integer root index n.
- Parametrised in exponent and mantissa width, so one RTL source covers half, single and double precision.
- Multi-cycle start/busy/done handshake. Used wherever the combinational float-power root path is too large or too inaccurate.
- Exact exponent split, then bit-serial significand search; rounding is toward zero.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width.
- N_W, 3, root-index width; n range 0..2^N_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when busy=0.
- a_in  in  EXP_W+MAN_W+1  operand, sampled on accepted start.
- n_in  in  N_W  root index, sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse; result valid.
- result  out  EXP_W+MAN_W+1  root; held until the next accepted start.

Behaviour:
- Reset (asynchronous, any state including mid-operation): go to IDLE; busy=0, done=0, result=0, all internal registers 0. The aborted operation produces no done.
- start while busy=1 is ignored.
- States: IDLE, CLASS, DIV, SEARCH, FIN.
- IDLE -> CLASS on accepted start (latch a_in, n_in).
- CLASS decodes special cases. NaN output is {0, all-ones exponent, all-ones fraction}.
  - a is NaN, or n=0 -> NaN.
  - a=+Inf -> +Inf.
  - a=-Inf: n odd -> -Inf; n even -> NaN.
  - a zero or subnormal (flush-to-zero) -> zero with the sign of a.
  - n=1 -> a unchanged.
  - a negative finite and n even -> NaN.
  - Any special case goes CLASS -> FIN directly. Latency start -> done = 2 cycles.
- General case: CLASS -> DIV.
  - DIV: restoring division of the unbiased exponent e = E - bias by n, taking EXP_W+1 cycles.
  - Division is floor: e = q*n + r, 0 <= r < n, including negative e.
  - X = 1.frac * 2^r, with X in [1, 2^n).
- SEARCH: find the largest y = 1.f (MAN_W fraction bits, implicit 1 fixed) with y^n <= X.
  - Work MSB to LSB over the MAN_W fraction bits.
  - Per bit: set trial bit; take n-1 cycles computing the trial^n product (multiply accumulator by trial, full width (MAN_W+1)*n bits, exact, no truncation); take 1 compare cycle against X shifted left by (n-1)*MAN_W; keep the bit if <=.
  - Cost is n cycles per bit.
- FIN: result = {sign(a), q+bias, f}. sign(a) is propagated only for odd n; the even-n negative case was already trapped as NaN.
  - The result is always normal; no overflow or underflow is possible for n>=2.
  - done=1 for this single cycle. busy drops the following cycle. The next state is IDLE.
- General latency start -> done = 1 + (EXP_W+1) + MAN_W*n + 1 cycles.
  - Single precision, n=2: 57 cycles.
  - Single precision, n=3: 80 cycles.
- start asserted in the cycle after done (busy=0) is accepted normally; back-to-back operation is supported.

Optional Feature:
- Macro: FP_NTH_ROOT_INEXACT_EN.
- Defined:
  - Extra output port inexact (1 bit), valid with done and held with result.
  - inexact=1 when the final y^n != X in the general case.
  - inexact=0 for all special cases and for exact roots.
  - The final y^n is recomputed in FIN-preceding cycles, adding n-1 cycles to general latency.
- Not defined: no port, no extra logic, latency as stated above.

Test Plan:
- a=0x41800000 (16), n=2 -> result=0x40800000 (4); done exactly 57 cycles after start; busy high throughout; inexact=0.
- a=0xC1000000 (-8), n=3 -> result=0xC0000000 (-2), done at cycle 80. Then a=0x3E000000 (0.125), n=3 -> 0x3F000000 (0.5), which checks negative-exponent floor division.
- a=0x40000000 (2), n=2 -> 0x3FB504F3 (truncated sqrt 2); inexact=1.
- Special cases, each with done at 2 cycles:
  - a=0xC1800000, n=2 -> 0x7FFFFFFF.
  - n=0 -> 0x7FFFFFFF.
  - a=0xFF800000, n=3 -> 0xFF800000.
  - a=0x80000000, n=5 -> 0x80000000.
  - a=0x3F123456, n=1 -> 0x3F123456.
- Handshake: start pulsed again mid-operation with a different a -> ignored, first result returned. rst_n pulsed low at cycle 20 of a 57-cycle operation -> busy/done/result=0 immediately, no done afterwards; a new start completes correctly.
- Parameter sweep with EXP_W=5, MAN_W=10: a=0x4C00 (16, half precision), n=2 -> 0x4400 (4); done at 1+6+20+1 = 28 cycles.
